// File: rtl/btb_update_ctrl_if.sv
// btb_update_ctrl_if
//   Bundles the execute-side update handshake and the BTB write port of
//   btb_update_ctrl into one interface.
//   master : execute stage / BTB side (drives ex_*, flush_req; observes outputs)
//   slave  : btb_update_ctrl (consumes ex_*, flush_req; drives ex_ready,
//            btb_wr_*, flush_busy, drop_cnt)
interface btb_update_ctrl_if #(
  parameter int PC_BITS = 11
);
  // execute-stage resolved-branch result
  logic               ex_valid;
  logic [PC_BITS-1:0] ex_pc;
  logic [PC_BITS-1:0] ex_target;
  logic               ex_taken;
  logic               ex_hit;
  logic [PC_BITS-1:0] ex_pred_target;
  logic               flush_req;
  logic               ex_ready;
  // BTB write port
  logic               btb_wr_enable;
  logic [PC_BITS-1:0] btb_wr_pc;
  logic [PC_BITS-1:0] btb_wr_target;
  logic               btb_wr_valid;
  // status
  logic               flush_busy;
  logic [7:0]         drop_cnt;

  modport master (
    output ex_valid, ex_pc, ex_target, ex_taken, ex_hit, ex_pred_target, flush_req,
    input  ex_ready, btb_wr_enable, btb_wr_pc, btb_wr_target, btb_wr_valid,
           flush_busy, drop_cnt
  );

  modport slave (
    input  ex_valid, ex_pc, ex_target, ex_taken, ex_hit, ex_pred_target, flush_req,
    output ex_ready, btb_wr_enable, btb_wr_pc, btb_wr_target, btb_wr_valid,
           flush_busy, drop_cnt
  );
endinterface

// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl
//   Write-side controller for the branch target buffer. Filters resolved
//   branches into BTB updates (allocate/retarget on taken mispredicts,
//   invalidate on not-taken hits), queues them in a small FIFO and issues at
//   most one registered write per cycle. A flush request runs an ascending
//   invalidation sweep over every BTB entry.
// Ports
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : btb_update_ctrl_if.slave
//          ex_* / flush_req in, ex_ready out (combinational from state)
//          btb_wr_* out (registered), flush_busy out, drop_cnt out (saturating)
module btb_update_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int PC_BITS    = 11,
  parameter int FIFO_DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  btb_update_ctrl_if.slave bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [PC_BITS-1:0] pc;
    logic [PC_BITS-1:0] target;
    logic               valid;
  } upd_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t state, state_next;

  // update queue
  upd_t [FIFO_DEPTH-1:0] fifo_mem;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  full, empty;

  logic [ADDR_WIDTH-1:0] sweep_idx;
  logic                  sweep_last;
  logic                  flush_busy_q;
  logic [7:0]            drop_q;

  // registered write port
  logic                  wr_en_q;
  upd_t                  wr_q;

  logic                  ready;
  logic                  flush_start;
  logic                  accept;
  logic                  qual_alloc, qual_inval;
  logic                  push, pop, drop;
  upd_t                  push_data;

  // ---------------------------------------------------------------------------
  // Qualification and handshake
  // ---------------------------------------------------------------------------
  // Fullness uses the registered count: a pop at this edge does not free a
  // slot for a push at the same edge.
  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign ready = (state == RUN) && !full && !flush_busy_q;

  // flush_busy stays high one cycle past the FSM returning to RUN (the last
  // sweep write is on the port then), which also blocks a restart there.
  assign flush_start = bus.flush_req && (state == RUN) && !flush_busy_q;

  // A flush at this edge wins over a same-cycle update, which is dropped.
  assign accept = bus.ex_valid && ready && !flush_start;
  assign drop   = bus.ex_valid && (!ready || flush_start);

  assign qual_alloc = bus.ex_taken &&
                      (!bus.ex_hit || (bus.ex_pred_target != bus.ex_target));
  assign qual_inval = !bus.ex_taken && bus.ex_hit;

  assign push = accept && (qual_alloc || qual_inval);
  assign pop  = (state == RUN) && !empty && !flush_start;

  always_comb begin
    push_data        = '0;
    push_data.pc     = bus.ex_pc;
    if (qual_alloc) begin
      push_data.target = bus.ex_target;
      push_data.valid  = 1'b1;
    end
  end

  assign sweep_last = (sweep_idx == {ADDR_WIDTH{1'b1}});

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (flush_start) state_next = FLUSH;
      FLUSH:   if (sweep_last)  state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Update FIFO (depth is a power of two, so pointers wrap naturally)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_start) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // storage needs no reset: occupancy gates every read
  always_ff @(posedge clk) begin
    if (push && !flush_start && !rst) fifo_mem[wr_ptr] <= push_data;
  end

  // ---------------------------------------------------------------------------
  // Sweep index, busy flag, drop counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst)                 sweep_idx <= '0;
    else if (flush_start)    sweep_idx <= '0;
    else if (state == FLUSH) sweep_idx <= sweep_idx + ADDR_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) flush_busy_q <= 1'b0;
    else     flush_busy_q <= flush_start || (state == FLUSH);
  end

  always_ff @(posedge clk) begin
    if (rst)                        drop_q <= '0;
    else if (drop && drop_q != '1)  drop_q <= drop_q + 8'd1;
  end

  // ---------------------------------------------------------------------------
  // Registered BTB write port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q <= 1'b0;
      wr_q    <= '0;
    end else if (state == FLUSH) begin
      wr_en_q       <= 1'b1;
      wr_q.pc       <= PC_BITS'(sweep_idx);
      wr_q.target   <= '0;
      wr_q.valid    <= 1'b0;
    end else if (pop) begin
      wr_en_q <= 1'b1;
      wr_q    <= fifo_mem[rd_ptr];
    end else begin
      wr_en_q <= 1'b0;
    end
  end

  assign bus.ex_ready      = ready;
  assign bus.btb_wr_enable = wr_en_q;
  assign bus.btb_wr_pc     = wr_q.pc;
  assign bus.btb_wr_target = wr_q.target;
  assign bus.btb_wr_valid  = wr_q.valid;
  assign bus.flush_busy    = flush_busy_q;
  assign bus.drop_cnt      = drop_q;

endmodule
